reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the single-write-enable register bank that the processor uses.
- Provides DEPTH registers of WIDTH bits, two asynchronous read ports and one synchronous write port with byte enables.
- Optional write-to-read bypass and an optional hardwired zero register.
- Integrated busy scoreboard: the issue stage claims a destination, writeback releases it, and the decode stage reads busy flags to detect RAW hazards.

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; 2 <= DEPTH <= 2**ADDR_W.
- ADDR_W, 5, address width of all address ports.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is visible on the read ports.

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset
- wr_enable  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- wr_byte_en  in  WIDTH/8  per-byte write mask; bit i covers bits [8i+7:8i]
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  WIDTH  read port A data
- rd_busy_a  out  1  busy flag of rd_addr_a
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  WIDTH  read port B data
- rd_busy_b  out  1  busy flag of rd_addr_b
- claim_enable  in  1  mark claim_addr as pending
- claim_addr  in  ADDR_W  destination being claimed
- busy  out  DEPTH  full scoreboard vector, bit n = register n pending

Behaviour:
- Reset:
  - When reset is low, all registers and all busy bits clear to 0 immediately, with no clock edge required.
  - This holds mid-operation: any write or claim in flight is discarded.
  - All outputs read 0 while reset is low.
- Write:
  - Occurs on the rising edge of clk when wr_enable=1 and reset=1.
  - Only bytes with wr_byte_en[i]=1 are updated; other bytes keep their old value.
  - wr_byte_en=0 with wr_enable=1 leaves data unchanged but still releases the busy bit.
- Read:
  - Combinational, zero latency.
  - rd_data_x = reg[rd_addr_x].
  - Both ports may address the same register.
- Bypass (BYPASS=1):
  - Applies when wr_enable=1 and wr_addr==rd_addr_x.
  - rd_data_x returns the merged value: new bytes where enabled, old bytes elsewhere.
  - rd_busy_x returns 0 in this case unless a claim to the same address is also active in this cycle.
- Bypass (BYPASS=0):
  - The read returns the old value until after the edge.
- Zero register (ZERO_REG=1):
  - Reads of address 0 return 0.
  - Writes and claims to address 0 are ignored; busy[0] is constantly 0.
- Scoreboard:
  - claim_enable=1 sets busy[claim_addr] at the edge.
  - wr_enable=1 clears busy[wr_addr] at the edge.
  - Simultaneous claim and write to the same address: busy stays 1, because the claim belongs to the new producer.
  - Claiming an already-busy register keeps it at 1; the register has a single pending producer, not a counter.
  - A write to a non-busy register is legal and leaves busy at 0.
- Out of range (address >= DEPTH):
  - Writes and claims are ignored.
  - Reads return data 0 and busy 0.
- No internal combinational loop: the read path is reg array plus bypass mux only.

Test Plan:
- Reset mid-run: load reg5=32'hDEADBEEF and claim reg7, then pull reset low between edges -> rd_data(5)=0 and busy=0 immediately. After reset returns high, still 0.
- Byte write: reg3=32'h11223344, then write 32'hAABBCCDD with wr_byte_en=4'b0101 -> reg3=32'h11BB33DD.
- Bypass: write reg9=32'h0000_00FF while rd_addr_a=9 with BYPASS=1 -> rd_data_a=32'hFF in the same cycle. With BYPASS=0 -> old value until the next edge.
- Scoreboard:
  - claim reg4 -> busy[4]=1 and rd_busy_a=1 at the next edge.
  - write reg4 -> busy[4]=0.
  - simultaneous claim and write to reg4 -> busy[4] stays 1.
- Zero register: write 32'h12345678 to reg0 and claim reg0 -> rd_data=0 and busy[0]=0 (ZERO_REG=1). With ZERO_REG=0 -> reads back 32'h12345678.
- Parametrisation: run WIDTH=16, DEPTH=8, ADDR_W=4. Write to addr 12 -> ignored, read of addr 12 = 0. Write to addr 7 with wr_byte_en=2'b10 -> only the upper byte is updated.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised register bank with two async read ports, one byte-masked
// write port, optional write bypass / zero register, and a busy scoreboard.
module reg_file_sb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_enable,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_byte_en,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [WIDTH-1:0]     rd_data_a,
  output logic                 rd_busy_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [WIDTH-1:0]     rd_data_b,
  output logic                 rd_busy_b,
  input  logic                 claim_enable,
  input  logic [ADDR_W-1:0]    claim_addr,
  output logic [DEPTH-1:0]     busy
);

  localparam int unsigned NB = WIDTH / 8;

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr_ok, claim_ok;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];
  logic              rd_busy [2];

  // Out-of-range addresses and (optionally) register 0 never hold state.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic ok;
    ok = (32'(a) < DEPTH);
    if (ZERO_REG != 0 && a == '0) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                             input logic [WIDTH-1:0] new_v,
                                             input logic [NB-1:0]    be);
    logic [WIDTH-1:0] res;
    res = old_v;
    for (int unsigned b = 0; b < NB; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign wr_ok    = wr_enable && addr_ok(wr_addr);
  assign claim_ok = claim_enable && addr_ok(claim_addr);

  // Claim is applied after the write release so a same-cycle claim wins.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && wr_addr == ADDR_W'(i)) begin
        regs_d[i] = merge(regs_q[i], wr_data, wr_byte_en);
        busy_d[i] = 1'b0;
      end
      if (claim_ok && claim_addr == ADDR_W'(i)) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
    end
  end

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      logic [WIDTH-1:0] d;
      logic             b;
      d = '0;
      b = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rd_addr[p] == ADDR_W'(i)) begin
          d = regs_q[i];
          b = busy_q[i];
        end
      end
      if (BYPASS != 0 && wr_ok && wr_addr == rd_addr[p]) begin
        d = merge(d, wr_data, wr_byte_en);
        b = claim_ok && (claim_addr == rd_addr[p]);
      end
      if (!reset) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[p] = d;
      rd_busy[p] = b;
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_busy_a = rd_busy[0];
  assign rd_data_b = rd_data[1];
  assign rd_busy_b = rd_busy[1];
  assign busy      = reset ? busy_q : '0;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default, no-bypass, no-zero-reg and a
// narrow/shallow instance share clock and reset.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        wr_enable, claim_enable;
  logic [4:0]  wr_addr, rd_addr_a, rd_addr_b, claim_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byte_en;

  logic [31:0] d_rda, d_rdb, n_rda, n_rdb, z_rda, z_rdb;
  logic        d_ba, d_bb, n_ba, n_bb, z_ba, z_bb;
  logic [31:0] d_busy, n_busy, z_busy;

  logic        s_wr_enable, s_claim_enable;
  logic [3:0]  s_wr_addr, s_rd_addr_a, s_rd_addr_b, s_claim_addr;
  logic [15:0] s_wr_data, s_rda, s_rdb;
  logic [1:0]  s_wr_byte_en;
  logic        s_ba, s_bb;
  logic [7:0]  s_busy;

  reg_file_sb u_dut (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_byte_en(wr_byte_en), .rd_addr_a(rd_addr_a),
    .rd_data_a(d_rda), .rd_busy_a(d_ba), .rd_addr_b(rd_addr_b),
    .rd_data_b(d_rdb), .rd_busy_b(d_bb), .claim_enable(claim_enable),
    .claim_addr(claim_addr), .busy(d_busy));

  reg_file_sb #(.BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_byte_en(wr_byte_en), .rd_addr_a(rd_addr_a),
    .rd_data_a(n_rda), .rd_busy_a(n_ba), .rd_addr_b(rd_addr_b),
    .rd_data_b(n_rdb), .rd_busy_b(n_bb), .claim_enable(claim_enable),
    .claim_addr(claim_addr), .busy(n_busy));

  reg_file_sb #(.ZERO_REG(0)) u_nozero (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_byte_en(wr_byte_en), .rd_addr_a(rd_addr_a),
    .rd_data_a(z_rda), .rd_busy_a(z_ba), .rd_addr_b(rd_addr_b),
    .rd_data_b(z_rdb), .rd_busy_b(z_bb), .claim_enable(claim_enable),
    .claim_addr(claim_addr), .busy(z_busy));

  reg_file_sb #(.WIDTH(16), .DEPTH(8), .ADDR_W(4)) u_small (
    .clk(clk), .reset(reset), .wr_enable(s_wr_enable), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .wr_byte_en(s_wr_byte_en), .rd_addr_a(s_rd_addr_a),
    .rd_data_a(s_rda), .rd_busy_a(s_ba), .rd_addr_b(s_rd_addr_b),
    .rd_data_b(s_rdb), .rd_busy_b(s_bb), .claim_enable(s_claim_enable),
    .claim_addr(s_claim_addr), .busy(s_busy));

  task automatic idle();
    wr_enable = 1'b0; wr_addr = '0; wr_data = '0; wr_byte_en = '0;
    claim_enable = 1'b0; claim_addr = '0;
    s_wr_enable = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_wr_byte_en = '0;
    s_claim_enable = 1'b0; s_claim_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    rd_addr_a = 5'd5; rd_addr_b = 5'd7;
    s_rd_addr_a = 4'd0; s_rd_addr_b = 4'd15;
    #3;
    checks++;
    if (d_rda !== 32'h0) begin errors++; $display("FAIL reset_rda got %h exp %h", d_rda, 32'h0); end
    checks++;
    if (d_busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", d_busy, 32'h0); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    wr_enable = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_byte_en = 4'hF;
    claim_enable = 1'b1; claim_addr = 5'd7;
    tick();
    idle();
    rd_addr_a = 5'd5; rd_addr_b = 5'd7;
    #1;
    checks++;
    if (d_rda !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_load got %h exp %h", d_rda, 32'hDEADBEEF); end
    checks++;
    if (d_bb !== 1'b1) begin errors++; $display("FAIL mid_claim got %b exp %b", d_bb, 1'b1); end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (d_rda !== 32'h0) begin errors++; $display("FAIL mid_async_data got %h exp %h", d_rda, 32'h0); end
    checks++;
    if (d_busy !== 32'h0 || d_bb !== 1'b0) begin errors++; $display("FAIL mid_async_busy got %h exp %h", d_busy, 32'h0); end
    wr_enable = 1'b1; wr_addr = 5'd5; wr_data = 32'h55AA55AA; wr_byte_en = 4'hF;
    #1;
    checks++;
    if (d_rda !== 32'h0) begin errors++; $display("FAIL reset_gates_bypass got %h exp %h", d_rda, 32'h0); end
    @(posedge clk);
    #1;
    idle();
    #2;
    reset = 1'b1;
    tick();
    checks++;
    if (d_rda !== 32'h0 || d_busy !== 32'h0) begin
      errors++; $display("FAIL after_reset got %h/%h exp 0/0", d_rda, d_busy);
    end
  endtask

  task automatic test_byte_write();
    wr_enable = 1'b1; wr_addr = 5'd3; wr_data = 32'h11223344; wr_byte_en = 4'hF;
    tick();
    wr_data = 32'hAABBCCDD; wr_byte_en = 4'b0101;
    tick();
    idle();
    rd_addr_a = 5'd3;
    #1;
    checks++;
    if (d_rda !== 32'h11BB33DD) begin errors++; $display("FAIL byte_write got %h exp %h", d_rda, 32'h11BB33DD); end
    claim_enable = 1'b1; claim_addr = 5'd3;
    tick();
    idle();
    wr_enable = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFFFFFF; wr_byte_en = 4'b0000;
    tick();
    idle();
    #1;
    checks++;
    if (d_busy[3] !== 1'b0) begin errors++; $display("FAIL be0_release got %b exp %b", d_busy[3], 1'b0); end
    checks++;
    if (d_rda !== 32'h11BB33DD) begin errors++; $display("FAIL be0_keep got %h exp %h", d_rda, 32'h11BB33DD); end
  endtask

  task automatic test_bypass();
    rd_addr_a = 5'd9;
    wr_enable = 1'b1; wr_addr = 5'd9; wr_data = 32'h000000FF; wr_byte_en = 4'hF;
    #1;
    checks++;
    if (d_rda !== 32'h000000FF) begin errors++; $display("FAIL bypass_on got %h exp %h", d_rda, 32'hFF); end
    checks++;
    if (n_rda !== 32'h0) begin errors++; $display("FAIL bypass_off_old got %h exp %h", n_rda, 32'h0); end
    tick();
    idle();
    #1;
    checks++;
    if (n_rda !== 32'h000000FF) begin errors++; $display("FAIL bypass_off_new got %h exp %h", n_rda, 32'hFF); end
    wr_enable = 1'b1; wr_addr = 5'd9; wr_data = 32'hAABBCCDD; wr_byte_en = 4'b0010;
    #1;
    checks++;
    if (d_rda !== 32'h0000CCFF) begin errors++; $display("FAIL bypass_merge got %h exp %h", d_rda, 32'h0000CCFF); end
    tick();
    idle();
    claim_enable = 1'b1; claim_addr = 5'd9;
    tick();
    idle();
    wr_enable = 1'b1; wr_addr = 5'd9; wr_byte_en = 4'b0000;
    #1;
    checks++;
    if (d_ba !== 1'b0) begin errors++; $display("FAIL bypass_busy_clr got %b exp %b", d_ba, 1'b0); end
    checks++;
    if (n_ba !== 1'b1) begin errors++; $display("FAIL nobypass_busy got %b exp %b", n_ba, 1'b1); end
    claim_enable = 1'b1; claim_addr = 5'd9;
    #1;
    checks++;
    if (d_ba !== 1'b1) begin errors++; $display("FAIL bypass_busy_claim got %b exp %b", d_ba, 1'b1); end
    tick();
    idle();
  endtask

  task automatic test_scoreboard();
    rd_addr_a = 5'd4; rd_addr_b = 5'd4;
    claim_enable = 1'b1; claim_addr = 5'd4;
    tick();
    idle();
    checks++;
    if (d_busy[4] !== 1'b1 || d_ba !== 1'b1 || d_bb !== 1'b1) begin
      errors++; $display("FAIL claim got %b%b%b exp 111", d_busy[4], d_ba, d_bb);
    end
    wr_enable = 1'b1; wr_addr = 5'd4; wr_data = 32'h4; wr_byte_en = 4'hF;
    tick();
    idle();
    checks++;
    if (d_busy[4] !== 1'b0) begin errors++; $display("FAIL release got %b exp %b", d_busy[4], 1'b0); end
    claim_enable = 1'b1; claim_addr = 5'd4;
    wr_enable = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; wr_byte_en = 4'hF;
    tick();
    idle();
    checks++;
    if (d_busy[4] !== 1'b1) begin errors++; $display("FAIL claim_and_write got %b exp %b", d_busy[4], 1'b1); end
    claim_enable = 1'b1; claim_addr = 5'd4;
    tick();
    idle();
    checks++;
    if (d_busy[4] !== 1'b1) begin errors++; $display("FAIL reclaim got %b exp %b", d_busy[4], 1'b1); end
    wr_enable = 1'b1; wr_addr = 5'd6; wr_data = 32'h6; wr_byte_en = 4'hF;
    tick();
    idle();
    checks++;
    if (d_busy !== 32'h0000_0210) begin errors++; $display("FAIL busy_vector got %h exp %h", d_busy, 32'h210); end
  endtask

  task automatic test_zero_reg();
    rd_addr_a = 5'd0;
    wr_enable = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; wr_byte_en = 4'hF;
    claim_enable = 1'b1; claim_addr = 5'd0;
    #1;
    checks++;
    if (d_rda !== 32'h0) begin errors++; $display("FAIL zero_bypass got %h exp %h", d_rda, 32'h0); end
    tick();
    idle();
    #1;
    checks++;
    if (d_rda !== 32'h0 || d_busy[0] !== 1'b0) begin
      errors++; $display("FAIL zero_reg got %h/%b exp 0/0", d_rda, d_busy[0]);
    end
    checks++;
    if (z_rda !== 32'h12345678 || z_busy[0] !== 1'b1) begin
      errors++; $display("FAIL nozero_reg got %h/%b exp 12345678/1", z_rda, z_busy[0]);
    end
  endtask

  task automatic test_small();
    s_rd_addr_a = 4'd12; s_rd_addr_b = 4'd15;
    s_wr_enable = 1'b1; s_wr_addr = 4'd12; s_wr_data = 16'hBEEF; s_wr_byte_en = 2'b11;
    s_claim_enable = 1'b1; s_claim_addr = 4'd12;
    #1;
    checks++;
    if (s_rda !== 16'h0) begin errors++; $display("FAIL oor_bypass got %h exp %h", s_rda, 16'h0); end
    tick();
    idle();
    checks++;
    if (s_rda !== 16'h0 || s_ba !== 1'b0 || s_busy !== 8'h0 || s_rdb !== 16'h0) begin
      errors++; $display("FAIL oor_ignored got %h/%b/%h exp 0/0/0", s_rda, s_ba, s_busy);
    end
    s_wr_enable = 1'b1; s_wr_addr = 4'd7; s_wr_data = 16'h1234; s_wr_byte_en = 2'b11;
    tick();
    s_wr_data = 16'hABCD; s_wr_byte_en = 2'b10;
    tick();
    idle();
    s_rd_addr_a = 4'd7;
    #1;
    checks++;
    if (s_rda !== 16'hAB34) begin errors++; $display("FAIL small_upper_byte got %h exp %h", s_rda, 16'hAB34); end
    s_claim_enable = 1'b1; s_claim_addr = 4'd7;
    tick();
    idle();
    checks++;
    if (s_busy !== 8'h80 || s_ba !== 1'b1) begin
      errors++; $display("FAIL small_claim got %h/%b exp 80/1", s_busy, s_ba);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_byte_write();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
